// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data memory with fixed latency, stalling the pipeline
// from the request cycle until the access completes.
module dmem_ctrl #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [15:0] addr,
  input  logic [15:0] sdata,
  output logic [15:0] ldata,
  output logic        stall,
  output logic        rdy
);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_ctrl: LATENCY must be within 1..15");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [15:0]           sdata_q, sdata_d, ldata_q, ldata_d;
  logic                  wr_q, wr_d;
  logic                  req, acc;
  logic [15:0]           mem [2**DEPTH_LOG2];
  logic                  unused_addr;
  assign unused_addr = ^addr[15:DEPTH_LOG2];
  assign req = re_mem | we_mem;
  // addr_d/sdata_d/wr_d carry the access operands on the edge entering DONE,
  // which for LATENCY==1 is the request edge itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    wr_d    = wr_q;
    acc     = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        addr_d  = addr[DEPTH_LOG2-1:0];
        sdata_d = sdata;
        wr_d    = we_mem;
        if (LATENCY == 1) begin
          state_d = DONE;
          acc     = 1'b1;
        end else begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 2);
        end
      end
      BUSY: if (cnt_q == 4'd0) begin
        state_d = DONE;
        acc     = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ldata_d = (acc && !wr_d) ? mem[addr_d] : ldata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      wr_q    <= 1'b0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      wr_q    <= wr_d;
      ldata_q <= ldata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && acc && wr_d) mem[addr_d] <= sdata_d;
  end
  assign ldata = ldata_q;
  assign stall = (state_q == IDLE && req) || state_q == BUSY;
  assign rdy   = state_q == DONE;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: drives a LATENCY=4 and a LATENCY=1 instance and checks them
// against a word-array reference model with per-cycle stall/rdy/ldata timing.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        re [2];
  logic        we [2];
  logic [15:0] ad [2];
  logic [15:0] sd [2];
  logic [15:0] ld [2];
  logic        st [2];
  logic        rd [2];
  int          lat [2] = '{4, 1};
  int          total = 0;
  int          bad = 0;
  logic [15:0] mm [2][4096];
  bit          mv [2][4096];
  logic [15:0] lexp [2];

  dmem_ctrl #(.DEPTH_LOG2(12), .LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n), .re_mem(re[0]), .we_mem(we[0]), .addr(ad[0]),
    .sdata(sd[0]), .ldata(ld[0]), .stall(st[0]), .rdy(rd[0]));
  dmem_ctrl #(.DEPTH_LOG2(12), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .re_mem(re[1]), .we_mem(we[1]), .addr(ad[1]),
    .sdata(sd[1]), .ldata(ld[1]), .stall(st[1]), .rdy(rd[1]));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input int d, input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL d%0d_%s observed=%h expected=%h", d, tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input int d);
    @(negedge clk);
    re[d] = 1'b0;
    we[d] = 1'b0;
    #1;
    chk(d, "idle_stall", {15'd0, st[d]}, 16'd0);
    chk(d, "idle_rdy", {15'd0, rd[d]}, 16'd0);
    chk(d, "idle_ldata", ld[d], lexp[d]);
  endtask

  // One access: request in cycle 0, stall through cycle L-1, rdy in cycle L.
  task automatic access(input int d, input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] s, input bit hold);
    logic [11:0] i;
    i = a[11:0];
    @(negedge clk);
    re[d] = r;
    we[d] = w;
    ad[d] = a;
    sd[d] = s;
    for (int c = 0; c < lat[d]; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1 && !hold) begin
        re[d] = 1'b0;
        we[d] = 1'b0;
        ad[d] = 16'($urandom);
        sd[d] = 16'($urandom);
      end
      #1;
      chk(d, "stall", {15'd0, st[d]}, 16'd1);
      chk(d, "rdy_busy", {15'd0, rd[d]}, 16'd0);
      chk(d, "ldata_busy", ld[d], lexp[d]);
    end
    @(negedge clk);
    if (lat[d] == 1 && !hold) begin
      re[d] = 1'b0;
      we[d] = 1'b0;
    end
    if (w) begin
      mm[d][i] = s;
      mv[d][i] = 1'b1;
    end else if (r) begin
      lexp[d] = mm[d][i];
    end
    #1;
    chk(d, "rdy_done", {15'd0, rd[d]}, 16'd1);
    chk(d, "stall_done", {15'd0, st[d]}, 16'd0);
    chk(d, "ldata_done", ld[d], lexp[d]);
  endtask

  initial begin
    logic [15:0] a;
    bit          w, r, h;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      re[d] = 1'b0;
      we[d] = 1'b0;
      ad[d] = '0;
      sd[d] = '0;
      lexp[d] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_stall", {15'd0, st[d]}, 16'd0);
      chk(d, "rst_rdy", {15'd0, rd[d]}, 16'd0);
      chk(d, "rst_ldata", ld[d], 16'h0000);
    end
    rst_n = 1'b1;
    repeat (20) begin
      idle_chk(0);
      #1 chk(1, "idle1_stall", {15'd0, st[1]}, 16'd0);
    end
    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    chk(0, "beef", ld[0], 16'hBEEF);
    access(0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
    chk(0, "both_keeps_ldata", ld[0], 16'hBEEF);
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    chk(0, "both_readback", ld[0], 16'h1234);
    access(0, 1'b0, 1'b1, 16'h1005, 16'h0F0F, 1'b1);
    idle_chk(0);
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1);
    chk(0, "alias", ld[0], 16'h0F0F);
    idle_chk(0);
    idle_chk(0);
    access(0, 1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0);
    @(negedge clk);
    we[0] = 1'b1;
    ad[0] = 16'h0030;
    sd[0] = 16'hAAAA;
    #1 chk(0, "rw_stall0", {15'd0, st[0]}, 16'd1);
    @(negedge clk);
    we[0] = 1'b0;
    @(negedge clk);
    #1 chk(0, "rw_stall2", {15'd0, st[0]}, 16'd1);
    rst_n = 1'b0;
    lexp[0] = '0;
    lexp[1] = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "async_stall", {15'd0, st[d]}, 16'd0);
      chk(d, "async_rdy", {15'd0, rd[d]}, 16'd0);
      chk(d, "async_ldata", ld[d], 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk(0);
    access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
    chk(0, "abort_kept_old", ld[0], 16'h5555);
    access(1, 1'b0, 1'b1, 16'h0001, 16'h1111, 1'b0);
    access(1, 1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0);
    access(1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0);
    chk(1, "b2b_first", ld[1], 16'h1111);
    access(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
    chk(1, "b2b_second", ld[1], 16'h2222);
    access(1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1);
    idle_chk(1);
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        a = 16'($urandom) & 16'hF007;
        w = !mv[d][a[11:0]] || ($urandom_range(0, 1) == 1);
        r = w ? ($urandom_range(0, 1) == 1) : 1'b1;
        h = $urandom_range(0, 3) == 0;
        access(d, r, w, a, 16'($urandom), h);
        if (h) idle_chk(d);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Multi-cycle data-memory responder; it is the memory-side end of the CPU's MEM-stage interface (re_mem/we_mem/addr/sdata in, ldata out).
- Holds a word-addressed backing array and services one access at a time with a fixed, parameterised latency.
- Asserts stall toward the hazard-detection logic so the pipeline freezes until the access completes.
- Replaces the single-cycle data memory in the pipelined CPU when slow-memory operation is enabled.

Parameters:
- DEPTH_LOG2, 12, backing array holds 2^DEPTH_LOG2 16-bit words; index is addr[DEPTH_LOG2-1:0].
- LATENCY, 4, stall cycles per access, counting the request cycle. Legal range 1..15; values outside the range are a configuration error.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- re_mem  input  1  read request from the MEM stage.
- we_mem  input  1  write request from the MEM stage.
- addr  input  16  word address; bits above DEPTH_LOG2-1 are ignored.
- sdata  input  16  store data, sampled in the request cycle.
- ldata  output  16  read data, registered.
- stall  output  1  freeze the pipeline (IF_ID..MEM_WB) while high.
- rdy  output  1  one-cycle pulse marking the completion cycle.

Behaviour:
- Clocking/reset: one clock, asynchronous active-low reset (rst_n).
- Reset values: state=IDLE, cnt=0, ldata=16'h0000, rdy=0, stall=0, latched addr/data/op cleared.
  - Array contents are not cleared by reset.
  - Reset mid-access returns to IDLE immediately; a pending write is discarded and the array is untouched.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req = re_mem | we_mem.
  - If req: latch addr[DEPTH_LOG2-1:0], sdata and op. If both re_mem and we_mem are high, the write wins and ldata is not updated.
  - Next state on req: if LATENCY==1 go to DONE; otherwise go to BUSY with cnt=LATENCY-2.
  - No req: stay in IDLE.
- BUSY: if cnt==0 go to DONE, else cnt <= cnt-1. Request inputs are ignored.
- Access edge (the edge entering DONE):
  - Write: mem[addr_q] <= sdata_q.
  - Read: ldata <= mem[addr_q].
- DONE: rdy=1, stall=0; request inputs are ignored (the same instruction is still in MEM this cycle); next state IDLE unconditionally.
- stall = (IDLE & req) | BUSY.
  - stall is combinational on req in IDLE, so the request cycle itself is stalled.
  - Request seen in cycle t gives stall high in cycles t..t+LATENCY-1, with rdy=1 and ldata valid in cycle t+LATENCY.
- Back-to-back memory instructions: the second request arrives in IDLE at t+LATENCY+1; there is no lost or duplicated access.
- Between reads, ldata holds the last read value; writes never change ldata.
- Read-after-write to the same address returns the new data, because the write is committed before the next request can be accepted.
- Address aliasing: addr 16'h1005 and 16'h0005 hit the same word when DEPTH_LOG2=12.

Test Plan:
- Reset then idle, no requests: stall=0, rdy=0, ldata=0000 for 20 cycles. Assert rst_n low at an arbitrary edge: outputs go to reset values without waiting for clk.
- LATENCY=4, write addr=0x0010, sdata=0xBEEF in cycle 0: stall=1 in cycles 0..3, rdy=1 in cycle 4, ldata unchanged (0000).
  - Then read 0x0010 in cycle 5: stall=1 in cycles 5..8, rdy=1 and ldata=BEEF in cycle 9.
- LATENCY=1: read request in cycle 0 gives stall=1 in cycle 0 only, rdy=1 and valid ldata in cycle 1. Back-to-back reads of 0x0001 (=0x1111) then 0x0002 (=0x2222) return 1111 then 2222 with exactly one stall cycle each.
- Simultaneous re_mem=we_mem=1, addr=0x0020, sdata=0x1234: treated as a write; a subsequent read of 0x0020 returns 1234, and ldata is unchanged during the write.
- Reset mid-write: write 0x0030=0xAAAA over a prior 0x5555, pull rst_n low in BUSY cycle 2. stall drops to 0, state is IDLE, and a later read of 0x0030 returns 5555.
- Aliasing: write 0x1005=0x0F0F, read 0x0005 -> ldata=0F0F. Requests held high through DONE do not start a second access (exactly one rdy pulse per request edge sequence).
